// File: rtl/jk_universal_register_pkg.sv
// rtl/jk_universal_register_pkg.sv - mode and JK code constants for jk_universal_register
//
// Package jk_univ_pkg
//   MODE_*  : 3-bit operation select values driven on the mode bus signal
//   JK_*    : {j,k} pair codes understood by jk_bit_cell
package jk_univ_pkg;

    typedef logic [2:0] mode_t;
    typedef logic [1:0] jk_code_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_JK   = 3'b001;
    localparam mode_t MODE_LOAD = 3'b010;
    localparam mode_t MODE_UP   = 3'b011;
    localparam mode_t MODE_DOWN = 3'b100;
    localparam mode_t MODE_SHL  = 3'b101;
    localparam mode_t MODE_SHR  = 3'b110;
    localparam mode_t MODE_ROTL = 3'b111;

    localparam jk_code_t JK_HOLD = 2'b00;
    localparam jk_code_t JK_CLR  = 2'b01;
    localparam jk_code_t JK_SET  = 2'b10;
    localparam jk_code_t JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_universal_register_if.sv
// rtl/jk_universal_register_if.sv - control/data bus of jk_universal_register
//
// master drives: en, mode, j, k, d, sin_l, sin_r
// master reads : q, qbar, tc, ovf
// slave is the register itself.
interface jk_universal_register_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;
    logic             ovf;

    modport master (
        output en, mode, j, k, d, sin_l, sin_r,
        input  q, qbar, tc, ovf
    );

    modport slave (
        input  en, mode, j, k, d, sin_l, sin_r,
        output q, qbar, tc, ovf
    );
endinterface

// File: rtl/jk_universal_register_cell.sv
// rtl/jk_universal_register_cell.sv - single JK bit cell with synchronous active-low clear
//
// Ports: clk, _clr (sync active-low), en_i (update enable), j_i/k_i (JK pair),
//        q_o (bit state). RST_VAL is the value taken on clear.
module jk_bit_cell
    import jk_univ_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic _clr,
    input  logic en_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (!_clr) begin
            q_q <= RST_VAL;
        end else if (en_i) begin
            case ({j_i, k_i})
                JK_SET:  q_q <= 1'b1;
                JK_CLR:  q_q <= 1'b0;
                JK_TGL:  q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/jk_universal_register.sv
// rtl/jk_universal_register.sv - multi-mode register built from JK bit cells
//
// Ports: clk, _clr (sync active-low), bus (slave side of jk_universal_register_if:
//        en, mode, j, k, d, sin_l, sin_r in; q, qbar, tc, ovf out).
module jk_universal_register
    import jk_univ_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               MODULUS   = 256,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    _clr,
    jk_universal_register_if.slave  bus
);

    // Top count value, truncated to register width.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] nxt_d;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic             tc_w;
    logic             ovf_d;
    logic             ovf_q;

    // Target value for the arithmetic/shift modes.
    always_comb begin
        nxt_d = q_q;
        case (bus.mode)
            MODE_UP:   nxt_d = (q_q >= MAX_VAL) ? '0 : q_q + WIDTH'(1);
            MODE_DOWN: begin
                if (q_q == '0)          nxt_d = MAX_VAL;
                else if (q_q > MAX_VAL) nxt_d = MAX_VAL;
                else                    nxt_d = q_q - WIDTH'(1);
            end
            MODE_SHL:  nxt_d = {q_q[WIDTH-2:0], bus.sin_l};
            MODE_SHR:  nxt_d = {bus.sin_r, q_q[WIDTH-1:1]};
            MODE_ROTL: nxt_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            default:   nxt_d = q_q;
        endcase
    end

    // Map each mode onto per-bit j/k. Computed modes toggle exactly the bits
    // that differ from the target (j=k=1), leaving the rest on hold.
    always_comb begin
        j_d = nxt_d ^ q_q;
        k_d = nxt_d ^ q_q;
        case (bus.mode)
            MODE_JK: begin
                j_d = bus.j;
                k_d = bus.k;
            end
            MODE_LOAD: begin
                j_d = bus.d;
                k_d = ~bus.d;
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_bit_cell #(
            .RST_VAL (RESET_VAL[i])
        ) u_cell (
            .clk  (clk),
            ._clr (_clr),
            .en_i (bus.en),
            .j_i  (j_d[i]),
            .k_i  (k_d[i]),
            .q_o  (q_q[i])
        );
    end

    assign tc_w  = bus.en & (((bus.mode == MODE_UP)   & (q_q >= MAX_VAL)) |
                             ((bus.mode == MODE_DOWN) & (q_q == '0)));
    // tc already carries en, so a disabled edge clears ovf.
    assign ovf_d = tc_w;

    always_ff @(posedge clk) begin
        if (!_clr) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign bus.q    = q_q;
    assign bus.qbar = ~q_q;
    assign bus.tc   = tc_w;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_jk_universal_register.sv
// tb/tb_jk_universal_register.sv - scoreboard bench for jk_universal_register
module tb_jk_universal_register;

    localparam int W   = 4;
    localparam int MOD = 10;

    localparam logic [2:0] M_HOLD = 3'd0, M_JK = 3'd1, M_LOAD = 3'd2, M_UP = 3'd3,
                           M_DOWN = 3'd4, M_SHL = 3'd5, M_SHR = 3'd6, M_ROTL = 3'd7;

    typedef struct {
        int q;
        int ovf;
        int tc;
    } exp_t;

    logic clk = 1'b0;
    logic clr_n;

    jk_universal_register_if #(.WIDTH(W)) bus ();

    jk_universal_register #(
        .WIDTH     (W),
        .MODULUS   (MOD),
        .RESET_VAL (4'h0)
    ) dut (
        .clk  (clk),
        ._clr (clr_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int   mq     = 0;
    int   movf   = 0;
    bit   mvalid = 1'b0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: mid-cycle, compare what the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("q",    int'(bus.q),    e.q);
            chk("qbar", int'(bus.qbar), (~e.q) & 15);
            chk("tc",   int'(bus.tc),   e.tc);
            chk("ovf",  int'(bus.ovf),  e.ovf);
        end
    end

    // Drive one cycle's inputs right after an edge, record what should be visible
    // before the next edge, then advance the reference model across that edge.
    task automatic step(input logic clr, input logic en, input logic [2:0] mode,
                        input int jv, input int kv, input int dv,
                        input logic sl, input logic sr);
        int   tc_e;
        int   nq;
        exp_t e;
        @(posedge clk);
        #1;
        clr_n     = clr;
        bus.en    = en;
        bus.mode  = mode;
        bus.j     = 4'(jv);
        bus.k     = 4'(kv);
        bus.d     = 4'(dv);
        bus.sin_l = sl;
        bus.sin_r = sr;

        tc_e = (en && ((mode == M_UP && mq >= MOD - 1) || (mode == M_DOWN && mq == 0))) ? 1 : 0;
        if (mvalid) begin
            e.q = mq; e.ovf = movf; e.tc = tc_e;
            sb.push_back(e);
        end

        if (!clr) begin
            mq = 0; movf = 0; mvalid = 1'b1;
        end else if (!en) begin
            movf = 0;
        end else begin
            nq = mq;
            case (mode)
                M_JK: begin
                    for (int b = 0; b < W; b++) begin
                        int jb, kb, qb;
                        jb = (jv >> b) & 1; kb = (kv >> b) & 1; qb = (mq >> b) & 1;
                        if (jb == 1 && kb == 0) qb = 1;
                        else if (jb == 0 && kb == 1) qb = 0;
                        else if (jb == 1 && kb == 1) qb = 1 - qb;
                        nq = (nq & ~(1 << b)) | (qb << b);
                    end
                end
                M_LOAD: nq = dv & 15;
                M_UP:   nq = (mq >= MOD - 1) ? 0 : mq + 1;
                M_DOWN: nq = (mq == 0 || mq > MOD - 1) ? MOD - 1 : mq - 1;
                M_SHL:  nq = ((mq * 2) + int'(sl)) % 16;
                M_SHR:  nq = (int'(sr) * 8) + (mq / 2);
                M_ROTL: nq = ((mq * 2) % 16) + (mq / 8);
                default: nq = mq;
            endcase
            mq   = nq;
            movf = tc_e;
        end
    endtask

    initial begin
        clr_n = 1'b0; bus.en = 1'b1; bus.mode = M_LOAD; bus.j = '0; bus.k = '0;
        bus.d = 4'hF; bus.sin_l = 1'b0; bus.sin_r = 1'b0;

        // Reset beats LOAD, then release
        step(0, 1, M_LOAD, 0, 0, 15, 0, 0);
        step(0, 1, M_LOAD, 0, 0, 15, 0, 0);
        step(1, 1, M_LOAD, 0, 0, 15, 0, 0);
        // JK set/clear/toggle/hold
        step(1, 1, M_LOAD, 0, 0, 5, 0, 0);
        step(1, 1, M_JK, 12, 10, 0, 0, 0);
        step(1, 1, M_JK, 0, 0, 0, 0, 0);
        step(1, 1, M_JK, 15, 15, 0, 0, 0);
        // UP wrap and out-of-range UP
        step(1, 1, M_LOAD, 0, 0, 8, 0, 0);
        repeat (3) step(1, 1, M_UP, 0, 0, 0, 0, 0);
        step(1, 1, M_LOAD, 0, 0, 12, 0, 0);
        step(1, 1, M_UP, 0, 0, 0, 0, 0);
        // DOWN wrap and out-of-range DOWN
        step(1, 1, M_LOAD, 0, 0, 1, 0, 0);
        repeat (2) step(1, 1, M_DOWN, 0, 0, 0, 0, 0);
        step(1, 1, M_LOAD, 0, 0, 14, 0, 0);
        step(1, 1, M_DOWN, 0, 0, 0, 0, 0);
        // Shift / rotate
        step(1, 1, M_LOAD, 0, 0, 9, 0, 0);
        step(1, 1, M_SHL, 0, 0, 0, 1, 0);
        step(1, 1, M_SHR, 0, 0, 0, 0, 0);
        step(1, 1, M_LOAD, 0, 0, 8, 0, 0);
        step(1, 1, M_ROTL, 0, 0, 0, 0, 0);
        // Enable hold, then reset over an enabled UP
        step(1, 1, M_LOAD, 0, 0, 5, 0, 0);
        repeat (3) step(1, 0, M_UP, 0, 0, 0, 0, 0);
        step(0, 1, M_UP, 0, 0, 0, 0, 0);
        step(1, 1, M_LOAD, 0, 0, 9, 0, 0);
        step(1, 1, M_UP, 0, 0, 0, 0, 0);
        step(0, 1, M_DOWN, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) != 0),
                 3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        step(1, 1, M_HOLD, 0, 0, 0, 0, 0);
        step(1, 1, M_HOLD, 0, 0, 0, 0, 0);

        for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
